// File: rtl/uart_alu_sequencer.sv
// Frame controller: pops A, B and opcode bytes from the RX FIFO, runs them through the
// external ALU and pushes one result (or error) byte per frame into the TX FIFO.
module uart_alu_sequencer #(
  parameter int                  BUS_SIZE = 8,
  parameter int                  TIMEOUT  = 1024,
  parameter int                  CNT_W    = 16,
  parameter logic [BUS_SIZE-1:0] ERR_BYTE = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BUS_SIZE-1:0] i_rx_data,
  input  logic                i_rx_empty,
  output logic                o_rx_rd,
  output logic [BUS_SIZE-1:0] o_alu_a,
  output logic [BUS_SIZE-1:0] o_alu_b,
  output logic [BUS_SIZE-3:0] o_alu_op,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  input  logic                i_tx_full,
  output logic                o_tx_wr,
  output logic [BUS_SIZE-1:0] o_tx_data,
  output logic                o_busy,
  output logic                o_op_err,
  output logic                o_timeout,
  output logic [7:0]          o_frame_cnt
);

  localparam int               OP_W         = BUS_SIZE - 2;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {GET_A, GET_B, GET_OP, EXEC, SEND} state_t;

  state_t              state_reg, state_next;
  logic [BUS_SIZE-1:0] a_reg, a_next, b_reg, b_next, result_reg, result_next;
  logic [OP_W-1:0]     op_reg, op_next;
  logic                illegal_reg, illegal_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [7:0]          frame_reg, frame_next;
  logic                op_err_reg, op_err_next, timeout_reg, timeout_next;
  logic                rx_rd, tx_wr;

  // Both opcode-field bits must be clear and the low bits must name a supported operation.
  function automatic logic op_legal(input logic [BUS_SIZE-1:0] raw);
    logic ok;
    case (raw[OP_W-1:0])
      OP_W'(6'h20), OP_W'(6'h22), OP_W'(6'h24), OP_W'(6'h25),
      OP_W'(6'h26), OP_W'(6'h27), OP_W'(6'h03), OP_W'(6'h02): ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok && (raw[BUS_SIZE-1:BUS_SIZE-2] == 2'b00);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= GET_A;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      illegal_reg <= 1'b0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      frame_reg   <= '0;
      op_err_reg  <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      op_reg      <= op_next;
      illegal_reg <= illegal_next;
      result_reg  <= result_next;
      cnt_reg     <= cnt_next;
      frame_reg   <= frame_next;
      op_err_reg  <= op_err_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    illegal_next = illegal_reg;
    result_next  = result_reg;
    cnt_next     = cnt_reg;
    frame_next   = frame_reg;
    op_err_next  = 1'b0;
    timeout_next = 1'b0;
    rx_rd        = 1'b0;
    tx_wr        = 1'b0;
    case (state_reg)
      GET_A: begin
        cnt_next = '0;
        rx_rd    = ~i_rx_empty;
        if (rx_rd) begin
          a_next     = i_rx_data;
          state_next = GET_B;
        end
      end
      GET_B, GET_OP: begin
        rx_rd = ~i_rx_empty;
        if (rx_rd) begin
          cnt_next = '0;
          if (state_reg == GET_B) begin
            b_next     = i_rx_data;
            state_next = GET_OP;
          end else begin
            op_next      = i_rx_data[OP_W-1:0];
            illegal_next = ~op_legal(i_rx_data);
            state_next   = EXEC;
          end
        end else if (TIMEOUT > 0) begin
          // Abort the partial frame; A/B keep their last values.
          if (cnt_reg == TIMEOUT_LAST) begin
            cnt_next     = '0;
            timeout_next = 1'b1;
            state_next   = GET_A;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      EXEC: begin
        result_next = illegal_reg ? ERR_BYTE : i_alu_result;
        op_err_next = illegal_reg;
        state_next  = SEND;
      end
      SEND: begin
        tx_wr = ~i_tx_full;
        if (tx_wr) begin
          frame_next = frame_reg + 8'd1;
          state_next = GET_A;
        end
      end
      default: state_next = GET_A;
    endcase
  end

  // Strobes are gated with reset so nothing is popped or pushed while reset is held.
  assign o_rx_rd     = rx_rd & reset;
  assign o_tx_wr     = tx_wr & reset;
  assign o_alu_a     = a_reg;
  assign o_alu_b     = b_reg;
  assign o_alu_op    = op_reg;
  assign o_tx_data   = result_reg;
  assign o_busy      = (state_reg != GET_A);
  assign o_op_err    = op_err_reg;
  assign o_timeout   = timeout_reg;
  assign o_frame_cnt = frame_reg;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: queue-modelled RX/TX FIFOs, a reference ALU,
// directed frames followed by randomized frames with RX gaps and TX back-pressure.
module tb_uart_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_empty = 1'b1;
  logic       i_tx_full = 1'b0;
  logic [7:0] i_alu_result;
  logic       o_rx_rd, o_tx_wr, o_busy, o_op_err, o_timeout;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data, o_frame_cnt;
  logic [5:0] o_alu_op;

  always #5 clk = ~clk;

  uart_alu_sequencer #(.BUS_SIZE(8), .TIMEOUT(16), .CNT_W(16), .ERR_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .o_rx_rd(o_rx_rd), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_op_err(o_op_err),
    .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
  );

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rd_cyc_q[$];
  logic       tx_full_req = 1'b0;
  logic       rand_active = 1'b0;
  int         checks = 0, failures = 0;
  int         cyc = 0, wr_total = 0, wr_cyc_last = 0;
  int         op_err_seen = 0, timeout_seen = 0, illegal_sent = 0;
  logic [7:0] model_cnt = 8'h00;
  logic [7:0] legal_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

  function automatic logic is_legal_ref(input logic [7:0] op);
    foreach (legal_ops[i]) if (op == legal_ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] frame_result(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] op);
    return is_legal_ref(op) ? alu_ref(a, b, op[5:0]) : 8'hFF;
  endfunction

  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples strobes mid-cycle, scores TX pushes, then updates the FIFO models.
  initial begin : env
    logic       s_rd, s_wr;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      s_rd = o_rx_rd;
      s_wr = o_tx_wr;
      if (!reset) model_cnt = 8'h00;
      if (o_op_err) op_err_seen++;
      if (o_timeout) timeout_seen++;
      if (s_rd) begin
        rd_cyc_q.push_back(cyc);
        chk("rx_pop_nonempty", i_rx_empty, 0);
      end
      if (s_wr) begin
        chk("tx_push_notfull", i_tx_full, 0);
        chk("tx_expected_present", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_data", o_tx_data, e);
        end
        chk("frame_cnt_at_wr", o_frame_cnt, model_cnt);
        $display("TX byte=%02h frame_cnt=%0d cyc=%0d", o_tx_data, o_frame_cnt, cyc);
        model_cnt++;
        wr_total++;
        wr_cyc_last = cyc;
      end
      @(posedge clk);
      #1;
      if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      i_rx_empty = (rx_q.size() == 0);
      i_rx_data  = i_rx_empty ? 8'h00 : rx_q[0];
      i_tx_full  = tx_full_req;
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic preload_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_q.push_back(frame_result(a, b, op));
    if (!is_legal_ref(op)) illegal_sent++;
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int gap);
    logic [7:0] bytes [3];
    bytes = '{a, b, op};
    exp_q.push_back(frame_result(a, b, op));
    if (!is_legal_ref(op)) illegal_sent++;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, gap)) @(posedge clk);
      at_edge();
      rx_q.push_back(bytes[i]);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_rx_rd"}, o_rx_rd, 0);
    chk({tag, "_tx_wr"}, o_tx_wr, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_op_err"}, o_op_err, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_frame_cnt"}, o_frame_cnt, 0);
    chk({tag, "_alu_a"}, o_alu_a, 0);
    chk({tag, "_alu_b"}, o_alu_b, 0);
    chk({tag, "_alu_op"}, o_alu_op, 0);
    chk({tag, "_tx_data"}, o_tx_data, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin : stim
    int wr_before, to_before;
    logic [7:0] a, b, op;

    repeat (3) @(negedge clk);
    zero_check("reset");
    at_edge();
    reset = 1'b1;

    // 1: preloaded ADD frame, back-to-back pops, push two cycles after the opcode pop
    at_edge();
    rd_cyc_q.delete();
    preload_frame(8'h05, 8'h03, 8'h20);
    wait_drain("t1_drain", 50);
    chk("t1_rd_count", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() >= 3) begin
      chk("t1_rd_consec1", rd_cyc_q[1], rd_cyc_q[0] + 1);
      chk("t1_rd_consec2", rd_cyc_q[2], rd_cyc_q[0] + 2);
      chk("t1_wr_latency", wr_cyc_last, rd_cyc_q[2] + 2);
    end
    chk("t1_frame_cnt", o_frame_cnt, 1);

    // 2: illegal opcode yields the error byte and one op_err pulse
    at_edge();
    preload_frame(8'h0F, 8'h01, 8'h3F);
    wait_drain("t2_drain", 50);
    chk("t2_op_err_pulses", op_err_seen, 1);
    chk("t2_frame_cnt", o_frame_cnt, 2);

    // 3: TX full holds SEND with stable data
    wr_before = wr_total;
    at_edge();
    tx_full_req = 1'b1;
    preload_frame(8'h0A, 8'h04, 8'h22);
    repeat (14) @(negedge clk);
    chk("t3_no_wr_while_full", wr_total, wr_before);
    chk("t3_tx_data_held", o_tx_data, 8'h06);
    chk("t3_busy_in_send", o_busy, 1);
    repeat (3) @(negedge clk);
    chk("t3_tx_data_stable", o_tx_data, 8'h06);
    at_edge();
    tx_full_req = 1'b0;
    wait_drain("t3_drain", 50);
    chk("t3_single_wr", wr_total, wr_before + 1);

    // 4: stalled partial frame is aborted; A survives, next frame is clean
    to_before = timeout_seen;
    at_edge();
    rx_q.push_back(8'h11);
    repeat (22) @(negedge clk);
    chk("t4_timeout_pulse", timeout_seen, to_before + 1);
    chk("t4_idle_after_abort", o_busy, 0);
    chk("t4_a_kept", o_alu_a, 8'h11);
    push_frame(8'h02, 8'h03, 8'h20, 0);
    wait_drain("t4_drain", 60);
    chk("t4_single_timeout", timeout_seen, to_before + 1);

    // 5: reset mid-frame discards A/B and blocks pops while held
    at_edge();
    rx_q.push_back(8'h07);
    rx_q.push_back(8'h09);
    repeat (6) @(negedge clk);
    chk("t5_b_latched", o_alu_b, 8'h09);
    chk("t5_busy_mid_frame", o_busy, 1);
    at_edge();
    reset = 1'b0;
    #1;
    zero_check("t5_in_reset");
    rx_q.push_back(8'h01);
    repeat (3) @(negedge clk);
    chk("t5_no_rd_in_reset", o_rx_rd, 0);
    at_edge();
    reset = 1'b1;
    at_edge();
    exp_q.push_back(frame_result(8'h01, 8'h01, 8'h20));
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h20);
    wait_drain("t5_drain", 60);
    chk("t5_frame_cnt", o_frame_cnt, 1);

    // Randomized frames with RX gaps, illegal opcodes and random TX back-pressure
    to_before = timeout_seen;
    rand_active = 1'b1;
    fork
      while (rand_active) begin
        at_edge();
        tx_full_req = ($urandom_range(0, 3) == 0);
      end
    join_none
    for (int f = 0; f < 40; f++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : legal_ops[$urandom_range(0, 7)];
      push_frame(a, b, op, 4);
    end
    rand_active = 1'b0;
    repeat (3) @(posedge clk);
    at_edge();
    tx_full_req = 1'b0;
    wait_drain("rand_drain", 3000);
    chk("rand_no_timeout", timeout_seen, to_before);

    // 6: 256 back-to-back frames from reset wrap the frame counter to 0
    at_edge();
    reset = 1'b0;
    at_edge();
    reset = 1'b1;
    at_edge();
    chk("t6_cnt_start", o_frame_cnt, 0);
    wr_before = wr_total;
    for (int f = 0; f < 256; f++)
      preload_frame(8'($urandom), 8'($urandom), legal_ops[$urandom_range(0, 7)]);
    wait_drain("t6_drain", 3000);
    chk("t6_frame_cnt_wrap", o_frame_cnt, 0);
    chk("t6_wr_count", wr_total, wr_before + 256);

    chk("final_op_err_count", op_err_seen, illegal_sent);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
